// File: rtl/sseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan
//  Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//             seven-segment display. Every digit slot starts with a blanking
//             interval (all anodes off), followed by a show interval. The
//             digit select changes only while blanked, so the segment mux
//             settles before the next anode turns on. This prevents ghosting.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous reset, active-high
//             en         - scan enable; low freezes scanning and blanks display
//             digit_en   - per-digit enable mask (bit i low keeps anode i off)
//             dp         - digit position, select for the segment mux
//             an         - anode enables, active-low, bit i = digit i
//             frame_tick - one-cycle pulse when a 4-digit frame completes
//  Revision : 1.0 - initial release
// ============================================================================
module sseg_scan #(
    parameter int BLANK_CYCLES = 500,
    parameter int SHOW_CYCLES  = 49500,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_en,
    output logic [1:0] dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_SHOW  = 1'b1;

    localparam logic [CNT_W-1:0] c_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       dp_q,    dp_d;
    logic [3:0]       an_q,    an_d;
    logic             tick_q,  tick_d;

    // ------------------------------------------------------------------
    // State register (state, counter, and the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_BLANK;
            cnt_q   <= '0;
            dp_q    <= 2'd0;
            an_q    <= 4'b1111;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: with en low everything holds, which also means a
    // terminal count coinciding with en low is simply deferred.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q;
        if (en) begin
            case (state_q)
                c_ST_BLANK: begin
                    if (cnt_q == c_BLANK_LAST) begin
                        state_d = c_ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == c_SHOW_LAST) begin
                        // Advance the digit on the same edge the anodes go
                        // dark, so dp never moves under a lit digit.
                        state_d = c_ST_BLANK;
                        cnt_d   = '0;
                        dp_d    = dp_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: computed from the upcoming state so that the
    // registered outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        an_d   = 4'b1111;
        tick_d = 1'b0;
        if (en) begin
            if (state_d == c_ST_SHOW && digit_en[dp_d]) begin
                an_d = ~(4'b0001 << dp_d);
            end
            tick_d = (state_q == c_ST_SHOW) && (state_d == c_ST_BLANK) &&
                     (dp_q == 2'd3);
        end
    end

    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan
//  Purpose  : Self-checking bench for sseg_scan with BLANK_CYCLES=2,
//             SHOW_CYCLES=3. A reference model based on a position-within-
//             digit-period counter predicts dp/an/frame_tick for every cycle;
//             predictions are queued at stimulus time and compared after the
//             clock edge, together with display invariants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan;

    localparam int B = 2;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] digit_en;
    logic [1:0] dp;
    logic [3:0] an;
    logic       frame_tick;

    always #5 clk = ~clk;

    sseg_scan #(
        .BLANK_CYCLES (B),
        .SHOW_CYCLES  (S),
        .CNT_W        (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_en   (digit_en),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [1:0] dp;
        logic [3:0] an;
        logic       ft;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    // Reference model: position within the digit period and digit index.
    int         m_p = 0;
    logic [1:0] m_d = 2'd0;

    logic [1:0] prev_dp;
    logic       prev_ft;
    bit         have_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, predict, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic [3:0] de);
        exp_t x;
        exp_t got;
        @(negedge clk);
        rst      = r;
        en       = e;
        digit_en = de;
        if (r) begin
            m_p  = 0;
            m_d  = 2'd0;
            x.dp = 2'd0;
            x.an = 4'b1111;
            x.ft = 1'b0;
        end else if (!e) begin
            x.dp = m_d;
            x.an = 4'b1111;
            x.ft = 1'b0;
        end else begin
            if (m_p == B + S - 1) begin
                m_p  = 0;
                x.ft = (m_d == 2'd3);
                m_d  = m_d + 2'd1;
            end else begin
                m_p  = m_p + 1;
                x.ft = 1'b0;
            end
            x.dp = m_d;
            x.an = (m_p >= B && de[m_d]) ? ~(4'b0001 << m_d) : 4'b1111;
        end
        sb_q.push_back(x);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_eq("dp",         {6'd0, dp},         {6'd0, got.dp});
        check_eq("an",         {4'd0, an},         {4'd0, got.an});
        check_eq("frame_tick", {7'd0, frame_tick}, {7'd0, got.ft});
        check_eq("an_onehot",  {7'd0, ($countones(~an) <= 1)}, 8'd1);
        if (have_prev) begin
            if (dp != prev_dp)
                check_eq("dp_stable_while_lit", {4'd0, an}, 8'h0F);
            if (prev_ft)
                check_eq("tick_single", {7'd0, frame_tick}, 8'd0);
        end
        prev_dp   = dp;
        prev_ft   = frame_tick;
        have_prev = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        digit_en = 4'b0000;

        // Basic sequence and frame ticks, all digits enabled.
        step(1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 4'b1111);

        // Digit masking.
        step(1'b1, 1'b1, 4'b1010);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 4'b1010);

        // Pause during the second SHOW cycle of digit 2.
        step(1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 40 && !(m_d == 2'd2 && m_p == B + 1); i++)
            step(1'b0, 1'b1, 4'b1111);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'b1111);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 4'b1111);

        // Reset during the digit-1 SHOW slot, then restart.
        for (int i = 0; i < 40 && !(m_d == 2'd1 && m_p >= B); i++)
            step(1'b0, 1'b1, 4'b1111);
        step(1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 4'b1111);

        // Random en / digit_en with occasional reset.
        for (int i = 0; i < 10000; i++)
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
                 4'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
